csr_file_irq: RTL and testbench
===============================

Name: csr_file_irq

Overview:
- Parametrised machine-mode CSR file: next generation of the core's CSR register block.
- Adds the following on top of plain register storage:
  - interrupt pending/enable logic with synchronised external lines;
  - direct or vectored mtvec;
  - 64-bit mcycle/minstret;
  - WARL field legalisation;
  - registered trap/mret PC redirect.
- Sits in the MEM/WB stage beside the trap controller. Drives the fetch-redirect path and the interrupt request to the pipeline.

Parameters:
- XLEN, 32: data width. Only 32 is supported; the counter high halves assume 32.
- HART_ID, 0: value returned by mhartid.
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec.
- SYNC_STAGES, 2: flop stages on irq_ext/irq_timer/irq_soft. Legal values are 1..3.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- raddr  in  12  CSR read address
- rdata  out  XLEN  read data, combinational
- rd_illegal  out  1  raddr unmapped, combinational
- waddr  in  12  CSR write address
- wdata  in  XLEN  write operand
- csr_w  in  1  write strobe
- csr_wsc_mode  in  2  01 write, 10 set, 11 clear, 00 treated as write
- trap  in  1  trap commit strobe
- trap_cause  in  XLEN  mcause value; bit 31 = interrupt
- trap_pc  in  XLEN  PC saved to mepc
- trap_tval  in  XLEN  saved to mtval
- mret  in  1  mret commit strobe
- instr_retire  in  1  one instruction retired this cycle
- irq_ext, irq_timer, irq_soft  in  1 each  asynchronous interrupt lines
- irq_req  out  1  enabled interrupt pending
- irq_code  out  5  highest-priority pending cause: 11 ext > 3 soft > 7 timer
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  XLEN  fetch target
- mstatus  out  XLEN  live mstatus

Behaviour:
Address map:
- mstatus 300, misa 301 (RO, 0x4000_0100), mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344 (RO), mhartid F14 (RO).
- mcycle B00 / mcycleh B80, minstret B02 / minstreth B82.
- Unmapped read: rdata=0, rd_illegal=1. Unmapped or RO write: silently ignored.

Reset values:
- mstatus=0x0000_1888 (MIE=1, MPIE=1, MPP=11).
- mtvec=MTVEC_RESET.
- mie=0x0000_0888.
- All other CSRs, counters and sync flops = 0.
- redirect_valid=0, irq_req=0.

WARL rules:
- mstatus: only bits 3 and 7 are writable; MPP always reads 11.
- mepc: bits[1:0] forced 0.
- mtvec: bits[1:0] with value 2 or 3 keep the old mode. The base field is written regardless.
- mie: only bits 3, 7, 11 are writable.
- mip: bit 11 = sync(irq_ext), bit 7 = sync(irq_timer), bit 3 = sync(irq_soft), after SYNC_STAGES flops.

Interrupts:
- irq_req = mstatus.MIE & |(mip & mie), combinational from flops.
- irq_code is 0 when irq_req=0.

Priority when strobes coincide in the same cycle: trap > mret > csr_w. The lower-priority action is dropped entirely.

On trap:
- mepc<=trap_pc, mcause<=trap_cause, mtval<=trap_tval.
- MPIE<=MIE, MIE<=0.
- Next cycle: redirect_valid=1.
  - redirect_pc = mtvec base if mode=0, or if mode=1 and cause bit 31=0.
  - redirect_pc = base + 4*cause[4:0] if mode=1 and cause bit 31=1.

On mret:
- MIE<=MPIE, MPIE<=1.
- Next cycle: redirect_valid=1, redirect_pc=mepc (the value before any same-cycle change).

redirect_valid is high for exactly one cycle per event. A trap in the cycle after an mret produces a second pulse with the trap target.

csr_w read-modify-write uses the current register value. New values are visible on rdata the next cycle.

Reset asserted mid-operation clears any pending redirect pulse in the same cycle.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined:
  - mcycle +1 every cycle; minstret +1 when instr_retire.
  - Both are 64 bit and wrap 2^64-1 -> 0.
  - A CSR write to either half in a cycle overrides that counter's increment for that cycle.
  - The carry from low to high half is applied atomically.
- Undefined:
  - B00/B80/B02/B82 read 0, are not flagged illegal, and ignore writes.
  - No counter flops are synthesised.

Test Plan:
- Reset, then read 300/305/304 -> 0x1888 / MTVEC_RESET / 0x888; read 0x7C0 -> rdata=0, rd_illegal=1.
- mtvec=0x1001, irq_timer=1, mie=0x80 -> irq_req rises after SYNC_STAGES cycles with irq_code=7. Then trap with cause 0x8000_0007 and trap_pc=0x1234 -> mepc=0x1234, MIE=0, MPIE=1, next-cycle redirect_pc=0x101C with a one-cycle pulse.
- mret following the previous trap -> MIE=1, MPIE=1, next-cycle redirect_pc=0x1234. Same-cycle trap+mret+csr_w -> only the trap takes effect.
- Write mtvec=0x2003 -> mode stays as before, base=0x2000. Write mepc=0x13 -> reads 0x10. Set-mode mstatus with 0xFFFF_FFFF -> 0x1888.
- CSR_COUNTERS_EN: write mcycle=0xFFFF_FFFF, mcycleh=0 -> 2 cycles later reads mcycleh=1, mcycle=1. With instr_retire held high for 10 cycles, minstret=10.
- Assert rst for one cycle during a redirect pulse -> redirect_valid=0 immediately, all CSRs return to reset values.

Source files
------------

// File: rtl/csr_file_irq.sv
// csr_file_irq: machine-mode CSR file with synchronised interrupt lines, direct/vectored mtvec and
// registered trap/mret fetch redirect. Define CSR_COUNTERS_EN to build the 64-bit mcycle/minstret.
module csr_file_irq #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] HART_ID     = '0,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0,
   parameter int unsigned     SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     raddr,
   output logic [XLEN-1:0] rdata,
   output logic            rd_illegal,
   input  logic [11:0]     waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic            csr_w,
   input  logic [1:0]      csr_wsc_mode,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_tval,
   input  logic            mret,
   input  logic            instr_retire,
   input  logic            irq_ext,
   input  logic            irq_timer,
   input  logic            irq_soft,
   output logic            irq_req,
   output logic [4:0]      irq_code,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] mstatus
);

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MISA      = 12'h301;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MTVAL     = 12'h343;
   localparam logic [11:0] A_MIP       = 12'h344;
   localparam logic [11:0] A_MHARTID   = 12'hF14;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [XLEN-1:0] MIE_MASK = 32'h0000_0888;

   logic                   mie_bit_q, mie_bit_d, mpie_q, mpie_d;
   logic [XLEN-1:0]        mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
   logic [XLEN-1:0]        mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
   logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d, tmr_sync_q, tmr_sync_d, sw_sync_q, sw_sync_d;
   logic                   redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0]        redirect_pc_q, redirect_pc_d;
`ifdef CSR_COUNTERS_EN
   logic [63:0]            mcycle_q, mcycle_d, minstret_q, minstret_d;
`else
   logic                   unused_retire;
   assign unused_retire = instr_retire;
`endif

   logic [XLEN-1:0] mstatus_w, mip_w, pend_w, wval, mtvec_base;
   logic [XLEN:0]   rd_rd, wr_rd;
   logic            do_w;

   assign mstatus_w = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, mpie_q, 3'b000, mie_bit_q, 3'b000};

   always_comb begin
      mip_w     = '0;
      mip_w[11] = ext_sync_q[SYNC_STAGES-1];
      mip_w[7]  = tmr_sync_q[SYNC_STAGES-1];
      mip_w[3]  = sw_sync_q[SYNC_STAGES-1];
   end

   // Returns {illegal, data} for one CSR address.
   function automatic logic [XLEN:0] csr_read(input logic [11:0] addr);
      logic [XLEN:0] r;
      r = '0;
      case (addr)
         A_MSTATUS:  r[XLEN-1:0] = mstatus_w;
         A_MISA:     r[XLEN-1:0] = 32'h4000_0100;
         A_MIE:      r[XLEN-1:0] = mie_q;
         A_MTVEC:    r[XLEN-1:0] = mtvec_q;
         A_MSCRATCH: r[XLEN-1:0] = mscratch_q;
         A_MEPC:     r[XLEN-1:0] = mepc_q;
         A_MCAUSE:   r[XLEN-1:0] = mcause_q;
         A_MTVAL:    r[XLEN-1:0] = mtval_q;
         A_MIP:      r[XLEN-1:0] = mip_w;
         A_MHARTID:  r[XLEN-1:0] = HART_ID;
`ifdef CSR_COUNTERS_EN
         A_MCYCLE:    r[XLEN-1:0] = mcycle_q[31:0];
         A_MCYCLEH:   r[XLEN-1:0] = mcycle_q[63:32];
         A_MINSTRET:  r[XLEN-1:0] = minstret_q[31:0];
         A_MINSTRETH: r[XLEN-1:0] = minstret_q[63:32];
`else
         A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: r = '0;
`endif
         default:    r[XLEN] = 1'b1;
      endcase
      return r;
   endfunction

   assign rd_rd      = csr_read(raddr);
   assign rdata      = rd_rd[XLEN-1:0];
   assign rd_illegal = rd_rd[XLEN];
   assign wr_rd      = csr_read(waddr);
   assign do_w       = csr_w & ~trap & ~mret;
   assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};

   always_comb begin
      case (csr_wsc_mode)
         2'b10:   wval = wr_rd[XLEN-1:0] | wdata;
         2'b11:   wval = wr_rd[XLEN-1:0] & ~wdata;
         default: wval = wdata;
      endcase
   end

   always_comb begin
      ext_sync_d       = (ext_sync_q << 1) | SYNC_STAGES'(irq_ext);
      tmr_sync_d       = (tmr_sync_q << 1) | SYNC_STAGES'(irq_timer);
      sw_sync_d        = (sw_sync_q << 1) | SYNC_STAGES'(irq_soft);
      mie_bit_d        = mie_bit_q;
      mpie_d           = mpie_q;
      mie_d            = mie_q;
      mtvec_d          = mtvec_q;
      mscratch_d       = mscratch_q;
      mepc_d           = mepc_q;
      mcause_d         = mcause_q;
      mtval_d          = mtval_q;
      redirect_valid_d = trap | mret;
      redirect_pc_d    = redirect_pc_q;
      if (trap) begin
         mepc_d    = {trap_pc[XLEN-1:2], 2'b00};
         mcause_d  = trap_cause;
         mtval_d   = trap_tval;
         mpie_d    = mie_bit_q;
         mie_bit_d = 1'b0;
         // Vectored mode only offsets interrupts; exceptions land on the base.
         if (mtvec_q[0] && trap_cause[XLEN-1])
            redirect_pc_d = mtvec_base + {{(XLEN-7){1'b0}}, trap_cause[4:0], 2'b00};
         else
            redirect_pc_d = mtvec_base;
      end else if (mret) begin
         mie_bit_d     = mpie_q;
         mpie_d        = 1'b1;
         redirect_pc_d = mepc_q;
      end else if (do_w) begin
         case (waddr)
            A_MSTATUS: begin
               mie_bit_d = wval[3];
               mpie_d    = wval[7];
            end
            A_MIE:      mie_d      = wval & MIE_MASK;
            A_MTVEC:    mtvec_d    = {wval[XLEN-1:2], wval[1] ? mtvec_q[1:0] : wval[1:0]};
            A_MSCRATCH: mscratch_d = wval;
            A_MEPC:     mepc_d     = {wval[XLEN-1:2], 2'b00};
            A_MCAUSE:   mcause_d   = wval;
            A_MTVAL:    mtval_d    = wval;
            default:    ;
         endcase
      end
   end

`ifdef CSR_COUNTERS_EN
   // A write to either half replaces that counter's increment for the cycle.
   always_comb begin
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = instr_retire ? minstret_q + 64'd1 : minstret_q;
      if (do_w) begin
         case (waddr)
            A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wval};
            A_MCYCLEH:   mcycle_d   = {wval, mcycle_q[31:0]};
            A_MINSTRET:  minstret_d = {minstret_q[63:32], wval};
            A_MINSTRETH: minstret_d = {wval, minstret_q[31:0]};
            default:     ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mie_bit_q        <= 1'b1;
         mpie_q           <= 1'b1;
         mie_q            <= MIE_MASK;
         mtvec_q          <= MTVEC_RESET;
         mscratch_q       <= '0;
         mepc_q           <= '0;
         mcause_q         <= '0;
         mtval_q          <= '0;
         ext_sync_q       <= '0;
         tmr_sync_q       <= '0;
         sw_sync_q        <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         mie_bit_q        <= mie_bit_d;
         mpie_q           <= mpie_d;
         mie_q            <= mie_d;
         mtvec_q          <= mtvec_d;
         mscratch_q       <= mscratch_d;
         mepc_q           <= mepc_d;
         mcause_q         <= mcause_d;
         mtval_q          <= mtval_d;
         ext_sync_q       <= ext_sync_d;
         tmr_sync_q       <= tmr_sync_d;
         sw_sync_q        <= sw_sync_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign pend_w         = mip_w & mie_q;
   assign irq_req        = mie_bit_q & (|pend_w);
   assign irq_code       = !irq_req  ? 5'd0  :
                           pend_w[11] ? 5'd11 :
                           pend_w[3]  ? 5'd3  : 5'd7;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign mstatus        = mstatus_w;

endmodule

// File: tb/tb_csr_file_irq.sv
// Testbench for csr_file_irq: directed scenarios plus randomized traffic against a CSR-level model.
module tb_csr_file_irq;
   localparam int          SYNC      = 2;
   localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
   localparam logic [31:0] HART      = 32'h0000_0005;

   logic        clk = 1'b0, rst = 1'b1;
   logic [11:0] raddr = '0, waddr = '0;
   logic [31:0] rdata, wdata = '0, trap_cause = '0, trap_pc = '0, trap_tval = '0;
   logic        rd_illegal, csr_w = 1'b0, trap = 1'b0, mret = 1'b0, instr_retire = 1'b0;
   logic [1:0]  csr_wsc_mode = 2'b01;
   logic        irq_ext = 1'b0, irq_timer = 1'b0, irq_soft = 1'b0;
   logic        irq_req, redirect_valid;
   logic [4:0]  irq_code;
   logic [31:0] redirect_pc, mstatus;

   int n_checks = 0, n_fail = 0;

   csr_file_irq #(.XLEN(32), .HART_ID(HART), .MTVEC_RESET(MTVEC_RST), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rd_illegal(rd_illegal),
      .waddr(waddr), .wdata(wdata), .csr_w(csr_w), .csr_wsc_mode(csr_wsc_mode),
      .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
      .mret(mret), .instr_retire(instr_retire), .irq_ext(irq_ext), .irq_timer(irq_timer),
      .irq_soft(irq_soft), .irq_req(irq_req), .irq_code(irq_code),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mstatus(mstatus));

   always #50 clk = ~clk;

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

   // Reference model, kept at the level of architectural CSR values.
   bit          m_mie_b, m_mpie, m_rv;
   logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_rpc;
   logic [2:0]  hist [0:3];
`ifdef CSR_COUNTERS_EN
   logic [63:0] m_cyc, m_ins;
`endif

   logic [11:0] alist [0:15] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'h343, 12'h344, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                 12'h7C0, 12'h345};

   function automatic void model_reset();
      m_mie_b = 1; m_mpie = 1; m_rv = 0; m_rpc = 0;
      m_mie = 32'h888; m_mtvec = MTVEC_RST;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      for (int i = 0; i < 4; i++) hist[i] = 3'b000;
`ifdef CSR_COUNTERS_EN
      m_cyc = 0; m_ins = 0;
`endif
   endfunction

   function automatic logic [31:0] m_status();
      return 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie_b ? 32'h8 : 32'h0);
   endfunction

   function automatic logic [31:0] m_mip();
      logic [2:0] s;
      s = hist[SYNC-1];
      return (s[2] ? 32'h800 : 32'h0) + (s[1] ? 32'h80 : 32'h0) + (s[0] ? 32'h8 : 32'h0);
   endfunction

   function automatic bit m_ill(input logic [11:0] a);
      return !(a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                         12'h344, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82});
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return m_status();
         12'h301: return 32'h4000_0100;
         12'h304: return m_mie;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'h344: return m_mip();
         12'hF14: return HART;
`ifdef CSR_COUNTERS_EN
         12'hB00: return m_cyc[31:0];
         12'hB80: return m_cyc[63:32];
         12'hB02: return m_ins[31:0];
         12'hB82: return m_ins[63:32];
`endif
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit m_irq();
      return m_mie_b && ((m_mip() & m_mie) != 0);
   endfunction

   function automatic logic [4:0] m_code();
      logic [31:0] p;
      p = m_mip() & m_mie;
      if (!m_irq()) return 5'd0;
      if (p[11]) return 5'd11;
      if (p[3])  return 5'd3;
      return 5'd7;
   endfunction

   // Applies one clock edge worth of architectural effect for the inputs now driven.
   function automatic void model_edge();
      logic [31:0] cur, wv, base, nrpc;
      bit cw, iw;
      cw = 0; iw = 0; nrpc = m_rpc;
      if (trap) begin
         base = m_mtvec & 32'hFFFF_FFFC;
         nrpc = (m_mtvec[0] && trap_cause[31]) ? base + 4 * 32'(trap_cause[4:0]) : base;
         m_mepc = trap_pc & 32'hFFFF_FFFC; m_mcause = trap_cause; m_mtval = trap_tval;
         m_mpie = m_mie_b; m_mie_b = 0;
      end else if (mret) begin
         nrpc = m_mepc; m_mie_b = m_mpie; m_mpie = 1;
      end else if (csr_w) begin
         cur = m_read(waddr);
         wv = (csr_wsc_mode == 2'b10) ? (cur | wdata) : (csr_wsc_mode == 2'b11) ? (cur & ~wdata) : wdata;
         case (waddr)
            12'h300: begin m_mie_b = wv[3]; m_mpie = wv[7]; end
            12'h304: m_mie = wv & 32'h888;
            12'h305: m_mtvec = (wv[1:0] >= 2'd2) ? ((wv & 32'hFFFF_FFFC) | (m_mtvec & 32'h3)) : wv;
            12'h340: m_mscratch = wv;
            12'h341: m_mepc = wv & 32'hFFFF_FFFC;
            12'h342: m_mcause = wv;
            12'h343: m_mtval = wv;
`ifdef CSR_COUNTERS_EN
            12'hB00: begin m_cyc[31:0] = wv; cw = 1; end
            12'hB80: begin m_cyc[63:32] = wv; cw = 1; end
            12'hB02: begin m_ins[31:0] = wv; iw = 1; end
            12'hB82: begin m_ins[63:32] = wv; iw = 1; end
`endif
            default: ;
         endcase
      end
`ifdef CSR_COUNTERS_EN
      if (!cw) m_cyc = m_cyc + 1;
      if (!iw && instr_retire) m_ins = m_ins + 1;
`else
      if (cw || iw) m_rv = m_rv;
`endif
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {irq_ext, irq_timer, irq_soft};
      m_rv = trap || mret;
      m_rpc = nrpc;
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk); #1;
      csr_w = 0; trap = 0; mret = 0; instr_retire = 0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [1:0] m, input logic [31:0] d);
      csr_w = 1; waddr = a; csr_wsc_mode = m; wdata = d;
      tick();
   endtask

   task automatic test_reset();
      logic [11:0] ta [0:8] = '{12'h300, 12'h305, 12'h304, 12'h7C0, 12'h344, 12'h341, 12'hF14, 12'h301, 12'hB00};
      logic [31:0] te [0:8] = '{32'h1888, MTVEC_RST, 32'h888, 32'h0, 32'h0, 32'h0, HART, 32'h4000_0100, 32'h0};
      bit          ti [0:8] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
      rst = 1;
      repeat (2) @(posedge clk);
      #1; rst = 0; model_reset();
      for (int i = 0; i < 9; i++) begin
         raddr = ta[i]; #1;
         n_checks++;
         if (rdata !== te[i] || rd_illegal !== ti[i]) begin
            n_fail++;
            $display("FAIL reset_read[%h]: got %h/%b want %h/%b", ta[i], rdata, rd_illegal, te[i], ti[i]);
         end
      end
      n_checks++;
      if (irq_req !== 1'b0 || redirect_valid !== 1'b0 || mstatus !== 32'h1888) begin
         n_fail++;
         $display("FAIL reset_outputs: got irq=%b rv=%b mstatus=%h want 0 0 00001888", irq_req, redirect_valid, mstatus);
      end
   endtask

   task automatic test_irq_trap();
      int rise;
      rise = -1;
      wr(12'h305, 2'b01, 32'h1001);
      wr(12'h304, 2'b01, 32'h80);
      irq_timer = 1;
      for (int c = 1; c <= SYNC + 2; c++) begin
         tick();
         if (irq_req === 1'b1 && rise < 0) rise = c;
      end
      n_checks++;
      if (rise != SYNC || irq_code !== 5'd7) begin
         n_fail++;
         $display("FAIL irq_latency: got rise=%0d code=%0d want rise=%0d code=7", rise, irq_code, SYNC);
      end
      trap = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h1234; trap_tval = 32'hBAD;
      tick();
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h101C || mstatus !== 32'h1880 || irq_req !== 1'b0) begin
         n_fail++;
         $display("FAIL trap_redirect: got rv=%b pc=%h ms=%h irq=%b want 1 0000101c 00001880 0",
                  redirect_valid, redirect_pc, mstatus, irq_req);
      end
      raddr = 12'h341; #1;
      n_checks++;
      if (rdata !== 32'h1234) begin n_fail++; $display("FAIL trap_mepc: got %h want 00001234", rdata); end
      raddr = 12'h342; #1;
      n_checks++;
      if (rdata !== 32'h8000_0007) begin n_fail++; $display("FAIL trap_mcause: got %h want 80000007", rdata); end
      tick();
      n_checks++;
      if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL trap_pulse_width: got rv=%b want 0", redirect_valid); end
   endtask

   task automatic test_mret();
      mret = 1;
      tick();
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1234 || mstatus !== 32'h1888) begin
         n_fail++;
         $display("FAIL mret_redirect: got rv=%b pc=%h ms=%h want 1 00001234 00001888", redirect_valid, redirect_pc, mstatus);
      end
      tick();
      n_checks++;
      if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL mret_pulse_width: got rv=%b want 0", redirect_valid); end
      csr_w = 1; waddr = 12'h340; csr_wsc_mode = 2'b01; wdata = 32'hDEAD;
      mret = 1; trap = 1; trap_cause = 32'h2; trap_pc = 32'h500; trap_tval = 32'h0;
      tick();
      raddr = 12'h340; #1;
      n_checks++;
      if (redirect_pc !== 32'h1000 || mstatus !== 32'h1880 || rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL coincide_priority: got pc=%h ms=%h mscratch=%h want 00001000 00001880 00000000",
                  redirect_pc, mstatus, rdata);
      end
   endtask

   task automatic test_back_to_back();
      mret = 1;
      tick();
      trap = 1; trap_cause = 32'h8000_000B; trap_pc = 32'h600; trap_tval = 32'h0;
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h500) begin
         n_fail++;
         $display("FAIL b2b_first: got rv=%b pc=%h want 1 00000500", redirect_valid, redirect_pc);
      end
      tick();
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h102C) begin
         n_fail++;
         $display("FAIL b2b_second: got rv=%b pc=%h want 1 0000102c", redirect_valid, redirect_pc);
      end
      tick();
   endtask

   task automatic test_warl();
      logic [11:0] wa [0:7] = '{12'h305, 12'h341, 12'h300, 12'h300, 12'h304, 12'h301, 12'h305, 12'h305};
      logic [1:0]  wm [0:7] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01};
      logic [31:0] wd [0:7] = '{32'h2003, 32'h13, 32'hFFFF_FFFF, 32'h8, 32'hFFFF_FFFF, 32'h0, 32'h2000, 32'h2002};
      logic [31:0] we [0:7] = '{32'h2001, 32'h10, 32'h1888, 32'h1880, 32'h888, 32'h4000_0100, 32'h2000, 32'h2000};
      for (int i = 0; i < 8; i++) begin
         wr(wa[i], wm[i], wd[i]);
         raddr = wa[i]; #1;
         n_checks++;
         if (rdata !== we[i]) begin
            n_fail++;
            $display("FAIL warl[%0d] addr %h: got %h want %h", i, wa[i], rdata, we[i]);
         end
      end
      wr(12'h344, 2'b01, 32'hFFFF_FFFF);
      raddr = 12'h344; #1;
      n_checks++;
      if (rdata !== 32'h80) begin n_fail++; $display("FAIL mip_readonly: got %h want 00000080", rdata); end
      irq_timer = 0;
   endtask

   task automatic test_counters();
`ifdef CSR_COUNTERS_EN
      wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
      wr(12'hB80, 2'b01, 32'h0);
      tick(); tick();
      raddr = 12'hB80; #1;
      n_checks++;
      if (rdata !== 32'h1) begin n_fail++; $display("FAIL mcycleh_carry: got %h want 00000001", rdata); end
      raddr = 12'hB00; #1;
      n_checks++;
      if (rdata !== 32'h1) begin n_fail++; $display("FAIL mcycle_low: got %h want 00000001", rdata); end
      wr(12'hB02, 2'b01, 32'h0);
      wr(12'hB82, 2'b01, 32'h0);
      for (int i = 0; i < 10; i++) begin instr_retire = 1; tick(); end
      raddr = 12'hB02; #1;
      n_checks++;
      if (rdata !== 32'd10) begin n_fail++; $display("FAIL minstret_count: got %0d want 10", rdata); end
`else
      wr(12'hB00, 2'b01, 32'h1234);
      for (int i = 0; i < 4; i++) begin
         raddr = alist[10 + i]; #1;
         n_checks++;
         if (rdata !== 32'h0 || rd_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL counter_absent[%h]: got %h/%b want 0/0", alist[10 + i], rdata, rd_illegal);
         end
      end
`endif
   endtask

   task automatic test_random();
      int r;
      logic [11:0] a;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 7) == 0) irq_ext = ~irq_ext;
         if ($urandom_range(0, 7) == 0) irq_timer = ~irq_timer;
         if ($urandom_range(0, 7) == 0) irq_soft = ~irq_soft;
         r = $urandom_range(0, 99);
         trap = (r < 6) || (r == 50);
         mret = (r >= 6 && r < 11) || (r == 51);
         csr_w = (r >= 11 && r < 70);
         instr_retire = ($urandom_range(0, 1) == 1);
         waddr = alist[$urandom_range(0, 15)];
         csr_wsc_mode = 2'($urandom_range(0, 3));
         wdata = $urandom();
         trap_cause = ($urandom_range(0, 1) == 1 ? 32'h8000_0000 : 32'h0) | 32'($urandom_range(0, 31));
         trap_pc = $urandom() & 32'hFFFF_FFFC;
         trap_tval = $urandom();
         tick();
         n_checks++;
         if (redirect_valid !== m_rv || (m_rv && redirect_pc !== m_rpc)) begin
            n_fail++;
            $display("FAIL rand_redirect c=%0d: got %b/%h want %b/%h", c, redirect_valid, redirect_pc, m_rv, m_rpc);
         end
         n_checks++;
         if (irq_req !== m_irq() || irq_code !== m_code() || mstatus !== m_status()) begin
            n_fail++;
            $display("FAIL rand_irq c=%0d: got %b/%0d/%h want %b/%0d/%h", c, irq_req, irq_code, mstatus,
                     m_irq(), m_code(), m_status());
         end
         a = alist[$urandom_range(0, 15)];
         raddr = a; #1;
         n_checks++;
         if (rdata !== m_read(a) || rd_illegal !== m_ill(a)) begin
            n_fail++;
            $display("FAIL rand_read c=%0d addr %h: got %h/%b want %h/%b", c, a, rdata, rd_illegal, m_read(a), m_ill(a));
         end
      end
      irq_ext = 0; irq_timer = 0; irq_soft = 0;
   endtask

   task automatic test_reset_mid();
      logic [11:0] ta [0:4] = '{12'h300, 12'h305, 12'h304, 12'h341, 12'h342};
      logic [31:0] te [0:4] = '{32'h1888, MTVEC_RST, 32'h888, 32'h0, 32'h0};
      trap = 1; trap_cause = 32'h3; trap_pc = 32'h700; trap_tval = 32'h0;
      tick();
      n_checks++;
      if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: got rv=%b want 1", redirect_valid); end
      rst = 1; #1;
      n_checks++;
      if (redirect_valid !== 1'b0 || mstatus !== 32'h1888) begin
         n_fail++;
         $display("FAIL midreset_async: got rv=%b ms=%h want 0 00001888", redirect_valid, mstatus);
      end
      @(posedge clk); #1;
      rst = 0; model_reset();
      for (int i = 0; i < 5; i++) begin
         raddr = ta[i]; #1;
         n_checks++;
         if (rdata !== te[i]) begin
            n_fail++;
            $display("FAIL midreset_read[%h]: got %h want %h", ta[i], rdata, te[i]);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_irq_trap();
      test_mret();
      test_back_to_back();
      test_warl();
      test_counters();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
